// File: rtl/seq_rep_monitor.sv
// Multi-channel runtime checker for trigger |=> x[*N] ##1 y, x[->N] ##1 y and x[=N] ##1 y.
// Each channel captures its mode and N on start and reports registered pass/fail/overlap pulses.
module seq_rep_monitor #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         x,
    input  logic [NUM_CH-1:0]         y,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [CNT_W*NUM_CH-1:0]   rep_n,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         pass,
    output logic [NUM_CH-1:0]         fail,
    output logic [2*NUM_CH-1:0]       fail_code,
    output logic [NUM_CH-1:0]         overlap,
    output logic [7:0]                fail_total
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_COUNT  = 2'b01,
        S_CHK_Y  = 2'b10,
        S_WAIT_Y = 2'b11
    } state_t;

    localparam logic [1:0] M_CONS   = 2'b00;
    localparam logic [1:0] M_GOTO   = 2'b01;
    localparam logic [1:0] M_RSVD   = 2'b11;
    localparam logic [1:0] FC_VIOL  = 2'b01;
    localparam logic [1:0] FC_TMO   = 2'b10;
    localparam logic [1:0] FC_EXTRA = 2'b11;

    state_t             state_q [NUM_CH];
    state_t             state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [CNT_W-1:0]   n_q     [NUM_CH];
    logic [CNT_W-1:0]   n_d     [NUM_CH];
    logic [1:0]         mode_q  [NUM_CH];
    logic [1:0]         mode_d  [NUM_CH];
    logic [TO_W-1:0]    tmr_q   [NUM_CH];
    logic [TO_W-1:0]    tmr_d   [NUM_CH];

    logic [NUM_CH-1:0]   busy_d;
    logic [NUM_CH-1:0]   pass_d;
    logic [NUM_CH-1:0]   fail_d;
    logic [NUM_CH-1:0]   overlap_d;
    logic [2*NUM_CH-1:0] fail_code_d;
    logic [8:0]          fail_sum;
    logic [7:0]          fail_total_d;

    // Next-state, decision and start-acceptance logic for every channel
    always_comb begin
        busy_d      = '0;
        pass_d      = '0;
        fail_d      = '0;
        overlap_d   = '0;
        fail_code_d = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            n_d[ch]     = n_q[ch];
            mode_d[ch]  = mode_q[ch];
            tmr_d[ch]   = tmr_q[ch];

            case (state_q[ch])
                S_COUNT: begin
                    if (mode_q[ch] == M_CONS && !x[ch]) begin
                        fail_d[ch]              = 1'b1;
                        fail_code_d[2*ch +: 2]  = FC_VIOL;
                    end else if (x[ch]) begin
                        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                        if (cnt_q[ch] + CNT_W'(1) == n_q[ch])
                            state_d[ch] = (mode_q[ch] == M_CONS || mode_q[ch] == M_GOTO)
                                          ? S_CHK_Y : S_WAIT_Y;
                    end
                end
                S_CHK_Y: begin
                    if (y[ch]) begin
                        pass_d[ch] = 1'b1;
                    end else begin
                        fail_d[ch]             = 1'b1;
                        fail_code_d[2*ch +: 2] = FC_VIOL;
                    end
                end
                S_WAIT_Y: begin
                    if (y[ch]) begin
                        pass_d[ch] = 1'b1;
                    end else if (x[ch]) begin
                        fail_d[ch]             = 1'b1;
                        fail_code_d[2*ch +: 2] = FC_EXTRA;
                    end
                end
                default: ;
            endcase

            // Strong-semantics timer: a decision on the last sample beats the timeout
            if (state_q[ch] != S_IDLE && mode_q[ch] != M_CONS) begin
                if (!pass_d[ch] && !fail_d[ch] && tmr_q[ch] == TO_W'(TIMEOUT)) begin
                    fail_d[ch]             = 1'b1;
                    fail_code_d[2*ch +: 2] = FC_TMO;
                end else begin
                    tmr_d[ch] = tmr_q[ch] + TO_W'(1);
                end
            end

            if (pass_d[ch] || fail_d[ch])
                state_d[ch] = S_IDLE;

            if (start[ch] && mode[2*ch +: 2] != M_RSVD) begin
                if (state_q[ch] == S_IDLE || pass_d[ch] || fail_d[ch]) begin
                    state_d[ch] = S_COUNT;
                    cnt_d[ch]   = '0;
                    mode_d[ch]  = mode[2*ch +: 2];
                    n_d[ch]     = (rep_n[CNT_W*ch +: CNT_W] == '0)
                                  ? CNT_W'(1) : rep_n[CNT_W*ch +: CNT_W];
                    tmr_d[ch]   = TO_W'(1);
                end else begin
                    overlap_d[ch] = 1'b1;
                end
            end

            busy_d[ch] = (state_d[ch] != S_IDLE) || pass_d[ch] || fail_d[ch];
        end

        fail_sum     = 9'(fail_total) + 9'($countones(fail_d));
        fail_total_d = (fail_sum > 9'd255) ? 8'hFF : fail_sum[7:0];
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= S_IDLE;
                cnt_q[ch]   <= '0;
                n_q[ch]     <= '0;
                mode_q[ch]  <= '0;
                tmr_q[ch]   <= '0;
            end
            busy       <= '0;
            pass       <= '0;
            fail       <= '0;
            fail_code  <= '0;
            overlap    <= '0;
            fail_total <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                n_q[ch]     <= n_d[ch];
                mode_q[ch]  <= mode_d[ch];
                tmr_q[ch]   <= tmr_d[ch];
            end
            busy       <= busy_d;
            pass       <= pass_d;
            fail       <= fail_d;
            fail_code  <= fail_code_d;
            overlap    <= overlap_d;
            fail_total <= fail_total_d;
        end
    end

endmodule
